// File: rtl/simple_in_n_out_exerciser_pkg.sv
// Shared types and constants for the AND/OR unit exerciser.
package simple_in_n_out_exerciser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int VEC_W = 3;
  localparam logic [VEC_W-1:0] LAST_VEC = 3'd7;

  // A settle time of zero cycles is treated as one cycle.
  function automatic int eff_settle(input int s);
    return (s < 1) ? 1 : s;
  endfunction

endpackage

// File: rtl/simple_in_n_out_exerciser_settle_timer.sv
// Loadable down-counter with a zero flag, used to time each settle phase.
module simple_in_n_out_settle_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;

  // Load takes priority over decrement; the count never wraps below zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/simple_in_n_out_exerciser.sv
// Exhaustive exerciser for a three-input AND/OR unit: steps through all
// eight input vectors, holds each for a settle time, checks both responses
// and records a saturating mismatch count plus the first failing vector.
module simple_in_n_out_exerciser
  import simple_in_n_out_exerciser_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_WIDTH     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 out_1,
  input  logic                 out_2,
  output logic                 in_1,
  output logic                 in_2,
  output logic                 in_3,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic                 first_err_valid,
  output logic [VEC_W-1:0]     first_err_vec
);

  localparam int S_EFF = eff_settle(SETTLE_CYCLES);
  localparam int TMR_W = (S_EFF > 1) ? $clog2(S_EFF) : 1;
  // Timer is loaded with S-1 so SETTLE spans exactly S cycles.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(S_EFF - 1);

  state_e               state_q, state_d;
  logic [VEC_W-1:0]     vec_q, vec_d;
  logic [VEC_W-1:0]     in_q, in_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic                 pass_q, pass_d;
  logic                 fev_q, fev_d;
  logic [VEC_W-1:0]     fevec_q, fevec_d;
  logic                 tmr_load, tmr_dec, tmr_zero;
  logic                 mismatch;

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_WIDTH'(1);
  endfunction

  simple_in_n_out_settle_timer #(
    .WIDTH (TMR_W)
  ) u_settle_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (TMR_LOAD),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Ideal unit is AND/OR reduction of the vector; any differing output is one mismatch.
  assign mismatch = (out_1 != (&vec_q)) || (out_2 != (|vec_q));

  // Next-state and datapath updates for the exerciser sequence.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    in_d     = in_q;
    err_d    = err_q;
    pass_d   = pass_q;
    fev_d    = fev_q;
    fevec_d  = fevec_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          vec_d    = '0;
          in_d     = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          fev_d    = 1'b0;
          fevec_d  = '0;
          tmr_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_CHECK;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          err_d = sat_inc(err_q);
          if (!fev_q) begin
            fev_d   = 1'b1;
            fevec_d = vec_q;
          end
        end
        if (vec_q == LAST_VEC) begin
          // Pass is decided from the count including this final check.
          state_d = ST_DONE;
          in_d    = '0;
          pass_d  = (err_d == '0);
        end else begin
          state_d  = ST_SETTLE;
          vec_d    = vec_q + VEC_W'(1);
          in_d     = vec_q + VEC_W'(1);
          tmr_load = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers, all cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      in_q    <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      fev_q   <= 1'b0;
      fevec_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      in_q    <= in_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      fev_q   <= fev_d;
      fevec_q <= fevec_d;
    end
  end

  assign {in_3, in_2, in_1} = in_q;
  assign busy            = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done            = (state_q == ST_DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fevec_q;

endmodule

// File: tb/tb_simple_in_n_out_exerciser.sv
// Scoreboard bench: two exerciser instances (S=2/ERR_WIDTH=4 and
// S=0/ERR_WIDTH=3) each driving a behavioural AND/OR unit with selectable faults.
module tb_simple_in_n_out_exerciser;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Unit fault modes: 0 ideal, 1 out_2 stuck 0, 2 out_1 inverted, 3 out_1 wrong on vector 7 only
  logic [1:0] mode_a, mode_b;
  logic start_a, start_b;

  logic a_in1, a_in2, a_in3, a_busy, a_done, a_pass, a_fev, a_o1, a_o2;
  logic [3:0] a_err;
  logic [2:0] a_fevec;
  logic b_in1, b_in2, b_in3, b_busy, b_done, b_pass, b_fev, b_o1, b_o2;
  logic [2:0] b_err;
  logic [2:0] b_fevec;

  function automatic logic [1:0] unit_out(input logic [1:0] mode, input logic [2:0] v);
    logic o1, o2;
    o1 = v[0] & v[1] & v[2];
    o2 = v[0] | v[1] | v[2];
    case (mode)
      2'd1: o2 = 1'b0;
      2'd2: o1 = ~o1;
      2'd3: if (v == 3'd7) o1 = 1'b0;
      default: ;
    endcase
    return {o2, o1};
  endfunction

  assign {a_o2, a_o1} = unit_out(mode_a, {a_in3, a_in2, a_in1});
  assign {b_o2, b_o1} = unit_out(mode_b, {b_in3, b_in2, b_in1});

  simple_in_n_out_exerciser #(.SETTLE_CYCLES(2), .ERR_WIDTH(4)) u_dut_a (
    .clock(clock), .reset(reset), .start(start_a), .out_1(a_o1), .out_2(a_o2),
    .in_1(a_in1), .in_2(a_in2), .in_3(a_in3), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_count(a_err), .first_err_valid(a_fev), .first_err_vec(a_fevec)
  );

  simple_in_n_out_exerciser #(.SETTLE_CYCLES(0), .ERR_WIDTH(3)) u_dut_b (
    .clock(clock), .reset(reset), .start(start_b), .out_1(b_o1), .out_2(b_o2),
    .in_1(b_in1), .in_2(b_in2), .in_3(b_in3), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_count(b_err), .first_err_valid(b_fev), .first_err_vec(b_fevec)
  );

  typedef struct {
    int         edge_no;
    logic [3:0] err;
    logic       fev;
    logic [2:0] fevec;
    logic       pass;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Independent prediction of one full pass against the fault model.
  function automatic exp_t predict(input logic [1:0] mode, input int ew, input int edge_no);
    exp_t e;
    int cnt;
    logic [2:0] vv;
    logic [1:0] o;
    cnt = 0;
    e.fev = 1'b0;
    e.fevec = 3'd0;
    for (int v = 0; v < 8; v++) begin
      vv = 3'(v);
      o = unit_out(mode, vv);
      if ((o[0] != (vv == 3'd7)) || (o[1] != (vv != 3'd0))) begin
        if (cnt < (1 << ew) - 1) cnt++;
        if (!e.fev) begin
          e.fev = 1'b1;
          e.fevec = vv;
        end
      end
    end
    e.err = 4'(cnt);
    e.pass = (cnt == 0);
    e.edge_no = edge_no;
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (a_done) begin
      if (q_a.size() == 0) check("a_spurious_done", 1, 0);
      else begin
        e = q_a.pop_front();
        check("a_done_edge", cyc, e.edge_no);
        check("a_err", a_err, e.err);
        check("a_pass", a_pass, e.pass);
        check("a_fev", a_fev, e.fev);
        check("a_fevec", a_fevec, e.fevec);
        check("a_in_at_done", {a_in3, a_in2, a_in1}, 0);
        check("a_busy_at_done", a_busy, 0);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (b_done) begin
      if (q_b.size() == 0) check("b_spurious_done", 1, 0);
      else begin
        e = q_b.pop_front();
        check("b_done_edge", cyc, e.edge_no);
        check("b_err", b_err, e.err[2:0]);
        check("b_pass", b_pass, e.pass);
        check("b_fev", b_fev, e.fev);
        check("b_fevec", b_fevec, e.fevec);
      end
    end
  end

  // Pulse start for one cycle; an accepted start queues its predicted result.
  task automatic pulse(input bit which_b, input bit accepted);
    @(negedge clock);
    if (!which_b) begin
      start_a = 1'b1;
      if (accepted) q_a.push_back(predict(mode_a, 4, cyc + 1 + 24));
    end else begin
      start_b = 1'b1;
      if (accepted) q_b.push_back(predict(mode_b, 3, cyc + 1 + 16));
    end
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
    if (accepted && !which_b) begin
      check("a_busy_after_start", a_busy, 1);
      check("a_cleared_at_start", {a_err, a_pass, a_fev, a_fevec}, 0);
      check("a_in_vec0", {a_in3, a_in2, a_in1}, 0);
    end
  endtask

  task automatic wait_empty(input bit which_b, input int budget);
    int n;
    n = 0;
    while (((!which_b && q_a.size() != 0) || (which_b && q_b.size() != 0)) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!which_b && q_a.size() != 0) begin
      check("a_timeout", q_a.size(), 0);
      q_a.delete();
    end
    if (which_b && q_b.size() != 0) begin
      check("b_timeout", q_b.size(), 0);
      q_b.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    mode_a = 2'd0;
    mode_b = 2'd0;
    repeat (2) @(negedge clock);
    check("a_reset_outs", {a_in3, a_in2, a_in1, a_busy, a_done, a_pass, a_err, a_fev, a_fevec}, 0);
    check("b_reset_outs", {b_in3, b_in2, b_in1, b_busy, b_done, b_pass, b_err, b_fev, b_fevec}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // Ideal unit, fault variants, and recovery to pass=1
    mode_a = 2'd0; pulse(0, 1); wait_empty(0, 60);
    mode_a = 2'd1; pulse(0, 1); wait_empty(0, 60);
    mode_a = 2'd3; pulse(0, 1); wait_empty(0, 60);
    mode_a = 2'd0; pulse(0, 1); wait_empty(0, 60);
    repeat (5) @(negedge clock);
    check("a_pass_held", a_pass, 1);

    // Starts while busy and in the DONE cycle must be ignored
    mode_a = 2'd2; pulse(0, 1);
    repeat (4) @(negedge clock);
    pulse(0, 0);
    pulse(0, 0);
    n = 0;
    while (!a_done && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("a_done_seen", a_done, 1);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    check("a_idle_after_done_start", a_busy, 0);
    repeat (40) @(negedge clock);
    check("a_no_pending_after_ignored", q_a.size(), 0);

    // Asynchronous reset in the middle of a pass at vector 4
    mode_a = 2'd0; pulse(0, 1);
    n = 0;
    while ({a_in3, a_in2, a_in1} != 3'd4 && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("a_reached_vec4", {a_in3, a_in2, a_in1}, 4);
    #2 reset = 1'b1;
    #1;
    check("a_async_reset_outs", {a_in3, a_in2, a_in1, a_busy, a_done, a_pass, a_err, a_fev, a_fevec}, 0);
    q_a.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("a_idle_after_reset", a_busy, 0);
    pulse(0, 1); wait_empty(0, 60);

    // Zero settle cycles behaves as one; narrow counter saturates
    mode_b = 2'd0; pulse(1, 1); wait_empty(1, 40);
    mode_b = 2'd2; pulse(1, 1); wait_empty(1, 40);
    mode_b = 2'd1; pulse(1, 1); wait_empty(1, 40);

    check("a_pending_end", q_a.size(), 0);
    check("b_pending_end", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
